register_file_multiport: RTL
============================

// Module: register_file_multiport
// PURPOSE
//  Parametrised register file for the 32-bit non-pipelined datapath: N combinational read ports, one
//  synchronous write port, optional hardwired-zero register 0 and a sequential clear engine.
//  Sits between decode (register addresses) and ALU/writeback; the clear engine lets the
//  controller wipe architectural state without asserting global reset.
// PARAMETERS
//  DATA_WIDTH  32  width of each register
//  ADDR_WIDTH  5   address width; DEPTH = 2**ADDR_WIDTH registers
//  NUM_READ    2   number of independent read ports (>=1)
//  ZERO_REG    1   1: register 0 always reads 0, writes to it dropped silently; 0: ordinary register
// PORTS
//  clk            in   1                      system clock, all state updates on rising edge
//  rst_n          in   1                      asynchronous, active-low reset
//  read_register  in   NUM_READ*ADDR_WIDTH    read addresses, port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
//  read_data      out  NUM_READ*DATA_WIDTH    read data, port k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  write_register in   ADDR_WIDTH             write address
//  write_enable   in   1                      write strobe, sampled on rising edge
//  write_data     in   DATA_WIDTH             write data
//  clear_req      in   1                      1-cycle request to start sequential clear
//  busy           out  1                      clear engine active; writes rejected
//  clear_done     out  1                      1-cycle pulse after last register cleared
//  write_error    out  1                      1-cycle pulse: a write was rejected while busy
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers=0, FSM=IDLE, clear pointer=0, busy=0, clear_done=0,
//    write_error=0; read_data therefore reads 0 on every port.
//  - Reads: combinational, zero latency; read_data[k] = reg[read_register[k]]; with ZERO_REG=1,
//    address 0 returns 0. All ports independent; same address on several ports is legal.
//  - Write: in IDLE, write_enable=1 at rising edge -> reg[write_register] <= write_data; visible on
//    reads from the following cycle (1-cycle write-to-read latency unless BYPASS_EN).
//  - FSM states: IDLE, CLEAR.
//    IDLE: clear_req=1 -> CLEAR, ptr<=0, busy<=1 at that edge.
//    CLEAR: each cycle reg[ptr]<=0, ptr<=ptr+1; when ptr==DEPTH-1 the last clear is written,
//    -> IDLE, busy<=0, clear_done<=1 for one cycle. busy is high exactly DEPTH cycles.
//  - clear_req while in CLEAR: ignored (no restart, no extension).
//  - write_enable=1 while busy: write dropped, write_error=1 for the cycle after that edge.
//  - write_enable and clear_req same edge in IDLE: write commits, clear starts; the written
//    register is later cleared by the walk.
//  - Reads during CLEAR return live contents (partially cleared: addresses < ptr read 0).
//  - ptr is ADDR_WIDTH bits; wraps to 0 on exit, never exceeds DEPTH-1.
//  - rst_n asserted mid-clear: immediate abort, full reset state as above.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when in IDLE, write_enable=1 and read_register[k]==write_register
//  (and not address 0 with ZERO_REG=1), read_data[k]=write_data in the same cycle (write-through).
//  Not defined: read_data[k] returns the old value until the write edge; no forwarding path.
//  Bypass never active while busy.
// TESTING
//  1 Reset then write 0x12345678 to r5; next cycle read_register={5,0} -> port0=0x12345678, port1=0.
//  2 ZERO_REG=1: write 0xDEADBEEF to r0 -> read r0 = 0; no write_error.
//  3 Write r2=0xA, r7=0xB; clear_req 1 cycle -> busy high 32 cycles, clear_done one pulse at end,
//    then r2, r7 read 0; write to r3 during busy -> write_error pulse, r3 stays 0.
//  4 Same-cycle write r9=0x55 with read r9: with REGFILE_BYPASS_EN port reads 0x55 same cycle;
//    without, reads prior value (0) until next cycle.
//  5 Drop rst_n at ptr=10 during clear -> busy=0, clear_done=0 immediately; all reads 0; a new
//    write after release succeeds.
//  6 NUM_READ=3, DATA_WIDTH=16: write r1=0x1111, r4=0x4444; read {1,4,1} -> 0x1111,0x4444,0x1111.

Source files
------------

// File: rtl/register_file_multiport.sv
// Multiport register file: NUM_READ combinational read ports, one synchronous write port,
// optional hardwired-zero r0 and a sequential clear engine. Define REGFILE_BYPASS_EN for write-through reads.
module register_file_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_register,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    input  logic [ADDR_WIDTH-1:0]          write_register,
    input  logic                           write_enable,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           clear_req,
    output logic                           busy,
    output logic                           clear_done,
    output logic                           write_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic                    zero_target;

    // Writes aimed at a hardwired-zero r0 are silently discarded.
    assign zero_target = (ZERO_REG != 0) && (write_register == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            busy        <= 1'b0;
            clear_done  <= 1'b0;
            write_error <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            clear_done  <= 1'b0;
            write_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_enable && !zero_target) begin
                        regs[write_register] <= write_data;
                    end
                    if (clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[ptr] <= '0;
                    if (write_enable) begin
                        write_error <= 1'b1;
                    end
                    // Leaving on the last address keeps busy high for exactly DEPTH cycles.
                    if (ptr == LAST_ADDR) begin
                        state      <= IDLE;
                        ptr        <= '0;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] stored;

        assign addr   = read_register[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign stored = ((ZERO_REG != 0) && (addr == '0)) ? '0 : regs[addr];

`ifdef REGFILE_BYPASS_EN
        // Forward the pending write only while idle; a busy file rejects the write anyway.
        assign read_data[g*DATA_WIDTH +: DATA_WIDTH] =
            ((state == IDLE) && write_enable && !zero_target && (addr == write_register))
            ? write_data : stored;
`else
        assign read_data[g*DATA_WIDTH +: DATA_WIDTH] = stored;
`endif
    end

endmodule
